// File: rtl/operand_fetch_sb.sv
// Operand fetch and writeback stage with a pending-destination scoreboard for a 2R1W register file.
// Define OPFETCH_FWD_EN to bypass same-cycle writeback data into the fetched operands.
module operand_fetch_sb #(
  parameter int DATA_WIDTH  = 32,
  parameter int REG_NUM     = 32,
  parameter int REG_NUM_BIT = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  output logic                   id_ready,
  input  logic [REG_NUM_BIT-1:0] id_rs1,
  input  logic [REG_NUM_BIT-1:0] id_rs2,
  input  logic [REG_NUM_BIT-1:0] id_rd,
  input  logic                   id_rd_wen,
  output logic                   ex_valid,
  input  logic                   ex_ready,
  output logic [DATA_WIDTH-1:0]  ex_rs1_data,
  output logic [DATA_WIDTH-1:0]  ex_rs2_data,
  output logic [REG_NUM_BIT-1:0] ex_rd,
  output logic                   ex_rd_wen,
  input  logic                   wb_valid,
  input  logic [REG_NUM_BIT-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0]  wb_data,
  output logic [REG_NUM_BIT-1:0] rf_raddr_a,
  output logic [REG_NUM_BIT-1:0] rf_raddr_b,
  input  logic [DATA_WIDTH-1:0]  rf_rdata_a,
  input  logic [DATA_WIDTH-1:0]  rf_rdata_b,
  output logic [REG_NUM_BIT-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0]  rf_wdata,
  output logic                   rf_wen,
  output logic [REG_NUM-1:0]     sb_busy,
  output logic                   sb_err
);

  logic [REG_NUM-1:0]    busy;
  logic [REG_NUM-1:0]    busy_next;
  logic                  fwd_a;
  logic                  fwd_b;
  logic                  rs1_hz;
  logic                  rs2_hz;
  logic                  waw_hz;
  logic                  ex_free;
  logic                  accept;
  logic                  wb_live;
  logic [DATA_WIDTH-1:0] opnd_a;
  logic [DATA_WIDTH-1:0] opnd_b;

  assign rf_raddr_a = id_rs1;
  assign rf_raddr_b = id_rs2;
  assign rf_waddr   = wb_rd;
  assign rf_wdata   = wb_data;
  assign wb_live    = wb_valid && (wb_rd != '0);
  assign rf_wen     = rst_n && wb_live;
  assign sb_busy    = {busy[REG_NUM-1:1], 1'b0};

`ifdef OPFETCH_FWD_EN
  assign fwd_a = wb_valid && (wb_rd == id_rs1);
  assign fwd_b = wb_valid && (wb_rd == id_rs2);
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  assign rs1_hz  = (id_rs1 != '0) && busy[id_rs1] && !fwd_a;
  assign rs2_hz  = (id_rs2 != '0) && busy[id_rs2] && !fwd_b;
  assign waw_hz  = id_rd_wen && (id_rd != '0) && busy[id_rd] &&
                   !(wb_valid && (wb_rd == id_rd));
  assign ex_free = !ex_valid || ex_ready;
  assign id_ready = rst_n && !rs1_hz && !rs2_hz && !waw_hz && ex_free;
  assign accept   = id_valid && id_ready;

  // x0 reads as zero whatever the RF returns; the bypass only exists when forwarding is built in
  always_comb begin
    opnd_a = rf_rdata_a;
    opnd_b = rf_rdata_b;
    if (id_rs1 == '0)
      opnd_a = '0;
    else if (fwd_a)
      opnd_a = wb_data;
    if (id_rs2 == '0)
      opnd_b = '0;
    else if (fwd_b)
      opnd_b = wb_data;
  end

  // Writeback clears first so an issuing instruction can re-claim the same register
  always_comb begin
    busy_next = busy;
    if (wb_live)
      busy_next[wb_rd] = 1'b0;
    if (accept && id_rd_wen && (id_rd != '0))
      busy_next[id_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy        <= '0;
      sb_err      <= 1'b0;
      ex_valid    <= 1'b0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_rd       <= '0;
      ex_rd_wen   <= 1'b0;
    end else begin
      busy <= busy_next;
      if (wb_live && !busy[wb_rd])
        sb_err <= 1'b1;
      if (accept) begin
        ex_valid    <= 1'b1;
        ex_rs1_data <= opnd_a;
        ex_rs2_data <= opnd_b;
        ex_rd       <= id_rd;
        ex_rd_wen   <= id_rd_wen;
      end else if (ex_ready) begin
        ex_valid <= 1'b0;
      end
    end
  end

endmodule
